scan_slot_sync: RTL and testbench

//  Fully synchronous per-design slot on the tiny-design scan chain, directly downstream of scan_controller.

---
 rtl/scan_slot_if.sv | 22 ++
 rtl/scan_slot_sync.sv | 178 +++++++++++++++++
 tb/tb_scan_slot_sync.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/scan_slot_if.sv
// Scan chain link bundle: the four single-bit chain signals passed from one
// slot (or the scan controller) to the next.
interface scan_slot_if;
  logic scan_clk;
  logic scan_data;
  logic scan_select;
  logic scan_latch_en;

  modport master (
    output scan_clk,
    output scan_data,
    output scan_select,
    output scan_latch_en
  );

  modport slave (
    input scan_clk,
    input scan_data,
    input scan_select,
    input scan_latch_en
  );
endinterface

// File: rtl/scan_slot_sync.sv
// scan_slot_sync: one tiny-design slot on the scan chain, fully synchronous
// to the system clock. The incoming scan clock is treated as data: it is
// synchronized, glitch-filtered by a small FSM, and its filtered rising edge
// shifts (or parallel-loads) the slot shift register. A rising edge on the
// latch enable copies the shift register onto module_data_in. All chain
// signals are re-timed and forwarded to the next slot with matched latency.
//
// Optional feature macro: SCAN_SLOT_LATCH_CNT_EN adds an 8-bit wrapping
// latch_count output that increments on every module_data_in update.
module scan_slot_sync #(
  parameter int NUM_IOS     = 8,
  parameter int FILT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  scan_slot_if.slave         chain_in,
  scan_slot_if.master        chain_out,
  output logic [NUM_IOS-1:0] module_data_in,
  input  logic [NUM_IOS-1:0] module_data_out
`ifdef SCAN_SLOT_LATCH_CNT_EN
  ,
  output logic [7:0]         latch_count
`endif
);

  localparam int CNT_W = (FILT_CYCLES < 1) ? 1 : $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {ST_LO, ST_HI} state_t;

  // Stage p0/p1: two-flop synchronizer, bit order {clk, data, sel, lat}
  logic [3:0] sync_p0;
  logic [3:0] sync_p1;

  logic clk_s;
  logic data_s;
  logic sel_s;
  logic lat_s;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rise;
  logic             capture;

  logic             data_hold;
  logic             sel_hold;
  logic             data_eff;
  logic             sel_eff;

  logic [NUM_IOS-1:0] shift_q;
  logic               lat_q;
  logic               lat_edge;

  logic               clk_out_q;
  logic [FILT_CYCLES:0] sel_pipe;
  logic [FILT_CYCLES:0] lat_pipe;

  // Synchronize the four asynchronous chain inputs into the clk domain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {chain_in.scan_clk, chain_in.scan_data,
                  chain_in.scan_select, chain_in.scan_latch_en};
      sync_p1 <= sync_p0;
    end
  end

  assign clk_s  = sync_p1[3];
  assign data_s = sync_p1[2];
  assign sel_s  = sync_p1[1];
  assign lat_s  = sync_p1[0];

  // Filter FSM state and disagreement counter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_LO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Accept a new scan_clk level only after it has held for FILT_CYCLES samples
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    rise      = 1'b0;
    if (clk_s != (state == ST_HI)) begin
      if (cnt == CNT_LAST) begin
        state_nxt = (state == ST_LO) ? ST_HI : ST_LO;
        rise      = (state == ST_LO);
      end else begin
        cnt_nxt = cnt + CNT_ONE;
      end
    end
  end

  // Data/select are taken at the raw edge; with a one-sample filter the
  // capture and the rise coincide, so the live value is used directly.
  assign capture  = (state == ST_LO) && clk_s && (cnt == '0);
  assign data_eff = capture ? data_s : data_hold;
  assign sel_eff  = capture ? sel_s  : sel_hold;

  // Hold data/select seen on the first cycle of a candidate rising edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_hold <= 1'b0;
      sel_hold  <= 1'b0;
    end else if (capture) begin
      data_hold <= data_s;
      sel_hold  <= sel_s;
    end
  end

  // Shift register: parallel load or shift-in on each accepted rise
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q <= '0;
    end else if (rise) begin
      if (sel_eff) begin
        shift_q <= module_data_out;
      end else begin
        shift_q <= {shift_q[NUM_IOS-2:0], data_eff};
      end
    end
  end

  assign lat_edge = lat_s & ~lat_q;

  // Latch edge detect and module_data_in update (reads pre-shift contents)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lat_q          <= 1'b0;
      module_data_in <= '0;
    end else begin
      lat_q <= lat_s;
      if (lat_edge) begin
        module_data_in <= shift_q;
      end
    end
  end

`ifdef SCAN_SLOT_LATCH_CNT_EN
  // Count module_data_in updates, wrapping at 8 bits
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      latch_count <= 8'd0;
    end else if (lat_edge) begin
      latch_count <= latch_count + 8'd1;
    end
  end
`endif

  // Stage p2: re-timed chain outputs, select/latch delayed to match the clock path
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_out_q <= 1'b0;
      sel_pipe  <= '0;
      lat_pipe  <= '0;
    end else begin
      clk_out_q <= (state == ST_HI);
      sel_pipe  <= {sel_pipe[FILT_CYCLES-1:0], sel_s};
      lat_pipe  <= {lat_pipe[FILT_CYCLES-1:0], lat_s};
    end
  end

  assign chain_out.scan_clk      = clk_out_q;
  assign chain_out.scan_data     = shift_q[NUM_IOS-1];
  assign chain_out.scan_select   = sel_pipe[FILT_CYCLES];
  assign chain_out.scan_latch_en = lat_pipe[FILT_CYCLES];

endmodule

// File: tb/tb_scan_slot_sync.sv
// Directed testbench for scan_slot_sync at default parameters
// (NUM_IOS=8, FILT_CYCLES=2). Optional SCAN_SLOT_LATCH_CNT_EN section
// exercises the latch counter when the macro is defined.
module tb_scan_slot_sync;

  logic       clk;
  logic       reset_n;
  logic [7:0] module_data_in;
  logic [7:0] module_data_out;
`ifdef SCAN_SLOT_LATCH_CNT_EN
  logic [7:0] latch_count;
`endif

  int errors;
  int checks;

  scan_slot_if ci ();
  scan_slot_if co ();

  scan_slot_sync #(
    .NUM_IOS     (8),
    .FILT_CYCLES (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .chain_in        (ci),
    .chain_out       (co),
    .module_data_in  (module_data_in),
    .module_data_out (module_data_out)
`ifdef SCAN_SLOT_LATCH_CNT_EN
    ,
    .latch_count     (latch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full scan clock period with data/select held throughout
  task automatic scan_bit(input logic d, input logic s);
    ci.scan_data   = d;
    ci.scan_select = s;
    tick(1);
    ci.scan_clk = 1'b1;
    tick(6);
    ci.scan_clk = 1'b0;
    tick(6);
  endtask

  task automatic latch_pulse();
    ci.scan_latch_en = 1'b1;
    tick(6);
    chk("latch_en_out_hi", co.scan_latch_en, 1'b1);
    ci.scan_latch_en = 1'b0;
    tick(6);
  endtask

  initial begin
    logic [7:0] pre;
    logic [7:0] word;
    logic       seen_hi;
    errors = 0;
    checks = 0;
    reset_n          = 1'b0;
    ci.scan_clk      = 1'b0;
    ci.scan_data     = 1'b0;
    ci.scan_select   = 1'b0;
    ci.scan_latch_en = 1'b0;
    module_data_out  = 8'h00;

    // Reset state
    tick(3);
    chk("rst_mdi",      module_data_in, 8'h00);
    chk("rst_clk_out",  co.scan_clk, 1'b0);
    chk("rst_data_out", co.scan_data, 1'b0);
    chk("rst_sel_out",  co.scan_select, 1'b0);
    chk("rst_lat_out",  co.scan_latch_en, 1'b0);
    reset_n = 1'b1;
    tick(2);

    // Parallel load of 8'h3C with exact clock-path latency check
    module_data_out = 8'h3C;
    ci.scan_data    = 1'b0;
    ci.scan_select  = 1'b1;
    tick(1);
    ci.scan_clk = 1'b1;
    tick(4);
    chk("lat_clk_out_early", co.scan_clk, 1'b0);
    tick(1);
    chk("lat_clk_out_on", co.scan_clk, 1'b1);
    chk("sel_out_hi", co.scan_select, 1'b1);
    tick(1);
    ci.scan_clk = 1'b0;
    tick(6);
    chk("clk_out_lo", co.scan_clk, 1'b0);

    // Shift A5 in MSB first; loaded 3C comes out in order
    pre  = 8'h3C;
    word = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("load_out_bit%0d", i), co.scan_data, pre[7-i]);
      scan_bit(word[7-i], 1'b0);
    end
    chk("shift_msb_a5", co.scan_data, 1'b1);
    chk("sel_out_lo", co.scan_select, 1'b0);
    latch_pulse();
    chk("latch_a5", module_data_in, 8'hA5);

    // One-cycle glitch: no shift, no clock out
    ci.scan_data = 1'b0;
    tick(1);
    ci.scan_clk = 1'b1;
    tick(1);
    ci.scan_clk = 1'b0;
    seen_hi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (co.scan_clk) seen_hi = 1'b1;
    end
    chk("glitch_clk_out", seen_hi, 1'b0);
    chk("glitch_data_out", co.scan_data, 1'b1);
    latch_pulse();
    chk("glitch_latch", module_data_in, 8'hA5);

    // Four-cycle pulse: exactly one shift (A5 -> 4A)
    tick(1);
    ci.scan_clk = 1'b1;
    tick(4);
    ci.scan_clk = 1'b0;
    tick(8);
    chk("pulse4_data_out", co.scan_data, 1'b0);
    latch_pulse();
    chk("pulse4_latch", module_data_in, 8'h4A);

    // Reset mid-shift after 3 bits
    scan_bit(1'b1, 1'b0);
    scan_bit(1'b1, 1'b0);
    scan_bit(1'b1, 1'b0);
    reset_n = 1'b0;
    tick(1);
    chk("midrst_mdi", module_data_in, 8'h00);
    chk("midrst_data_out", co.scan_data, 1'b0);
    chk("midrst_clk_out", co.scan_clk, 1'b0);
    reset_n = 1'b1;
    tick(2);
    word = 8'h5A;
    for (int i = 0; i < 8; i++) scan_bit(word[7-i], 1'b0);
    latch_pulse();
    chk("midrst_fresh", module_data_in, 8'h5A);

    // Latch edge in the same cycle as the rise: pre-shift value latched
    ci.scan_data = 1'b1;
    tick(1);
    ci.scan_clk = 1'b1;
    tick(1);
    ci.scan_latch_en = 1'b1;
    tick(5);
    ci.scan_latch_en = 1'b0;
    ci.scan_clk      = 1'b0;
    tick(6);
    chk("collide_latch", module_data_in, 8'h5A);
    chk("collide_data_out", co.scan_data, 1'b1);
    latch_pulse();
    chk("collide_after", module_data_in, 8'hB5);

`ifdef SCAN_SLOT_LATCH_CNT_EN
    // Latch counter wrap: 257 pulses from reset
    reset_n = 1'b0;
    tick(1);
    chk("cnt_rst", latch_count, 8'd0);
    reset_n = 1'b1;
    tick(2);
    for (int i = 0; i < 257; i++) latch_pulse();
    chk("cnt_wrap", latch_count, 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
